// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared RISC-V encoding constants for the instruction encoder
// Purpose: ImmSel format codes, opcode constants and the canonical NOP word.
// Ports: none (package).
package rv_pkg;

    typedef enum logic [2:0] {
        IMM_I  = 3'b000,
        IMM_S  = 3'b001,
        IMM_SB = 3'b010,
        IMM_UJ = 3'b011,
        IMM_U  = 3'b100
    } imm_sel_e;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_JAL    = 7'h6F;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

endpackage

// File: rtl/imm_range_check.sv
// rtl/imm_range_check.sv - combinational immediate range/alignment checker
// Purpose: flags an immediate that cannot be represented in the selected format.
// Ports:
//   imm_sel  in  3   format code (rv_pkg::imm_sel_e encodings; others illegal)
//   imm      in  32  two's complement immediate
//   err      out 1   immediate out of range, misaligned, or illegal format
module imm_range_check
    import rv_pkg::*;
(
    input  logic [2:0]  imm_sel,
    input  logic [31:0] imm,
    output logic        err
);

    logic signed [31:0] simm;

    assign simm = $signed(imm);

    always_comb begin
        err = 1'b1;
        case (imm_sel)
            IMM_I, IMM_S: err = (simm < -32'sd2048) || (simm > 32'sd2047);
            // Branch/jump offsets are halfword aligned, so the top odd value is excluded.
            IMM_SB:       err = (simm < -32'sd4096) || (simm > 32'sd4094) || imm[0];
            IMM_UJ:       err = (simm < -32'sd1048576) || (simm > 32'sd1048574) || imm[0];
            IMM_U:        err = (imm[11:0] != 12'd0);
            default:      err = 1'b1;
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// rtl/inst_encoder.sv - two-stage valid/ready RISC-V instruction word encoder
// Purpose: packs immediate + register/function fields into a 32-bit instruction
// word for the selected format and flags unrepresentable immediates.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   in_valid/in_ready            input beat handshake
//   ImmSel, imm, rd, rs1, rs2,   input beat fields
//   funct3, opcode
//   out_valid/out_ready          output word handshake
//   out_word, out_err            encoded word and its error flag
//   err_count                    saturating count of delivered erroneous words
module inst_encoder
    import rv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  ImmSel,
    input  logic [31:0] imm,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  opcode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic        out_err,
    output logic [7:0]  err_count
);

    // Stage 1: raw input beat
    logic        s1_valid_q,  s1_valid_d;
    logic [2:0]  s1_sel_q,    s1_sel_d;
    logic [31:0] s1_imm_q,    s1_imm_d;
    logic [4:0]  s1_rd_q,     s1_rd_d;
    logic [4:0]  s1_rs1_q,    s1_rs1_d;
    logic [4:0]  s1_rs2_q,    s1_rs2_d;
    logic [2:0]  s1_funct3_q, s1_funct3_d;
    logic [6:0]  s1_opcode_q, s1_opcode_d;

    // Stage 2: packed word
    logic        s2_valid_q,  s2_valid_d;
    logic [31:0] s2_word_q,   s2_word_d;
    logic        s2_err_q,    s2_err_d;
    logic [7:0]  err_count_q, err_count_d;

    logic        s2_adv;
    logic        in_fire;
    logic        err1;
    logic [31:0] word1;

    imm_range_check u_imm_range_check (
        .imm_sel (s1_sel_q),
        .imm     (s1_imm_q),
        .err     (err1)
    );

    // out_ready reaches in_ready combinationally so a full pipe can drain
    // and refill in the same cycle.
    assign s2_adv   = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_adv;
    assign in_fire  = in_valid && in_ready;

    always_comb begin
        word1 = NOP_WORD;
        case (s1_sel_q)
            IMM_I:  word1 = {s1_imm_q[11:0], s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q};
            IMM_S:  word1 = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_funct3_q,
                             s1_imm_q[4:0], s1_opcode_q};
            IMM_SB: word1 = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_funct3_q,
                             s1_imm_q[4:1], s1_imm_q[11], s1_opcode_q};
            IMM_UJ: word1 = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12],
                             s1_rd_q, s1_opcode_q};
            IMM_U:  word1 = {s1_imm_q[31:12], s1_rd_q, s1_opcode_q};
            default: word1 = NOP_WORD;
        endcase
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_sel_d    = s1_sel_q;
        s1_imm_d    = s1_imm_q;
        s1_rd_d     = s1_rd_q;
        s1_rs1_d    = s1_rs1_q;
        s1_rs2_d    = s1_rs2_q;
        s1_funct3_d = s1_funct3_q;
        s1_opcode_d = s1_opcode_q;
        s2_valid_d  = s2_valid_q;
        s2_word_d   = s2_word_q;
        s2_err_d    = s2_err_q;
        err_count_d = err_count_q;

        if (in_fire) begin
            s1_valid_d  = 1'b1;
            s1_sel_d    = ImmSel;
            s1_imm_d    = imm;
            s1_rd_d     = rd;
            s1_rs1_d    = rs1;
            s1_rs2_d    = rs2;
            s1_funct3_d = funct3;
            s1_opcode_d = opcode;
        end else if (s2_adv) begin
            s1_valid_d  = 1'b0;
        end

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_word_d = word1;
                s2_err_d  = err1;
            end
        end

        if (s2_valid_q && out_ready && s2_err_q && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_sel_q    <= 3'd0;
            s1_imm_q    <= 32'd0;
            s1_rd_q     <= 5'd0;
            s1_rs1_q    <= 5'd0;
            s1_rs2_q    <= 5'd0;
            s1_funct3_q <= 3'd0;
            s1_opcode_q <= 7'd0;
            s2_valid_q  <= 1'b0;
            s2_word_q   <= 32'd0;
            s2_err_q    <= 1'b0;
            err_count_q <= 8'd0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sel_q    <= s1_sel_d;
            s1_imm_q    <= s1_imm_d;
            s1_rd_q     <= s1_rd_d;
            s1_rs1_q    <= s1_rs1_d;
            s1_rs2_q    <= s1_rs2_d;
            s1_funct3_q <= s1_funct3_d;
            s1_opcode_q <= s1_opcode_d;
            s2_valid_q  <= s2_valid_d;
            s2_word_q   <= s2_word_d;
            s2_err_q    <= s2_err_d;
            err_count_q <= err_count_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_word  = s2_word_q;
    assign out_err   = s2_err_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_inst_encoder.sv
// tb/tb_inst_encoder.sv - scoreboard testbench for inst_encoder
module tb_inst_encoder;
    import rv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  ImmSel;
    logic [31:0] imm;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  opcode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic        out_err;
    logic [7:0]  err_count;

    always #5 clk = ~clk;

    inst_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ImmSel    (ImmSel),
        .imm       (imm),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct3    (funct3),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_err   (out_err),
        .err_count (err_count)
    );

    typedef struct {
        logic [31:0] word;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   checks  = 0;
    int   errors  = 0;
    int   exp_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every output transfer and tracks the
    // expected saturating error count.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sb_q.delete();
            exp_cnt = 0;
        end else begin
            check("err_count", 32'(err_count), 32'(exp_cnt));
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word actual=%h required=none", out_word);
                end else begin
                    e = sb_q.pop_front();
                    check("out_word", out_word, e.word);
                    check("out_err", 32'(out_err), 32'(e.err));
                    if (e.err && exp_cnt < 255) exp_cnt++;
                end
            end
        end
    end

    task automatic send(input logic [2:0] sel, input logic [31:0] im, input logic [4:0] rd_i,
                        input logic [4:0] rs1_i, input logic [4:0] rs2_i, input logic [2:0] f3,
                        input logic [6:0] op, input logic [31:0] exp_w, input logic exp_e);
        bit done = 1'b0;
        ImmSel   = sel;
        imm      = im;
        rd       = rd_i;
        rs1      = rs1_i;
        rs2      = rs2_i;
        funct3   = f3;
        opcode   = op;
        in_valid = 1'b1;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            if (in_ready) begin
                sb_q.push_back('{exp_w, exp_e});
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=in_ready_low required=accept");
        end
    endtask

    task automatic drain();
        int c = 0;
        while (sb_q.size() != 0 && c < 400) begin
            @(posedge clk);
            #1;
            c++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d required=0", sb_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        ImmSel    = 3'd0;
        imm       = 32'd0;
        rd        = 5'd0;
        rs1       = 5'd0;
        rs2       = 5'd0;
        funct3    = 3'd0;
        opcode    = 7'd0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_word", out_word, 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // Latency: visible after the second edge
        send(IMM_I, 32'd5, 5'd1, 5'd0, 5'd0, 3'd0, OP_IMM, 32'h0050_0093, 1'b0);
        check("lat_not_yet", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("lat_valid", 32'(out_valid), 32'd1);
        check("lat_word", out_word, 32'h0050_0093);

        send(IMM_S,  32'd8,          5'd0, 5'd3, 5'd2, 3'd2, OP_STORE,  32'h0021_A423, 1'b0);
        send(IMM_SB, 32'hFFFF_FFFC,  5'd0, 5'd0, 5'd0, 3'd0, OP_BRANCH, 32'hFE00_0EE3, 1'b0);
        send(IMM_UJ, 32'd2048,       5'd1, 5'd0, 5'd0, 3'd0, OP_JAL,    32'h0010_00EF, 1'b0);

        // Error words, count steps 1..4
        send(IMM_SB, 32'd3,          5'd0, 5'd0, 5'd0, 3'd0, OP_BRANCH, 32'h0000_0163, 1'b1);
        send(IMM_I,  32'd4096,       5'd1, 5'd0, 5'd0, 3'd0, OP_IMM,    32'h0000_0093, 1'b1);
        send(IMM_U,  32'h1234_5001,  5'd1, 5'd0, 5'd0, 3'd0, OP_LUI,    32'h1234_50B7, 1'b1);
        send(3'b111, 32'd0,          5'd7, 5'd7, 5'd7, 3'd7, 7'h7F,     NOP_WORD,      1'b1);
        drain();
        check("err_count_4", 32'(err_count), 32'd4);

        // Range boundaries
        send(IMM_I,  32'd2047,       5'd1, 5'd0, 5'd0, 3'd0, OP_IMM,    32'h7FF0_0093, 1'b0);
        send(IMM_I,  32'd2048,       5'd1, 5'd0, 5'd0, 3'd0, OP_IMM,    32'h8000_0093, 1'b1);
        send(IMM_SB, 32'd4094,       5'd0, 5'd0, 5'd0, 3'd0, OP_BRANCH, 32'h7E00_0FE3, 1'b0);
        send(IMM_SB, 32'd4096,       5'd0, 5'd0, 5'd0, 3'd0, OP_BRANCH, 32'h8000_0063, 1'b1);
        send(IMM_UJ, 32'hFFF0_0000,  5'd0, 5'd0, 5'd0, 3'd0, OP_JAL,    32'h8000_006F, 1'b0);
        send(IMM_S,  32'hFFFF_F800,  5'd0, 5'd2, 5'd1, 3'd0, OP_STORE,  32'h8011_0023, 1'b0);
        drain();
        check("err_count_6", 32'(err_count), 32'd6);

        // Backpressure: two beats fit, third waits, output holds
        out_ready = 1'b0;
        send(IMM_I, 32'hFFFF_FFFF, 5'd5, 5'd6, 5'd0, 3'd0, OP_IMM, 32'hFFF3_0293, 1'b0);
        send(IMM_U, 32'hABCD_E000, 5'd2, 5'd0, 5'd0, 3'd0, OP_LUI, 32'hABCD_E137, 1'b0);
        ImmSel   = IMM_S;
        imm      = 32'hFFFF_F800;
        rs1      = 5'd2;
        rs2      = 5'd1;
        funct3   = 3'd0;
        opcode   = OP_STORE;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_word", out_word, 32'hFFF3_0293);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(IMM_S, 32'hFFFF_F800, 5'd0, 5'd2, 5'd1, 3'd0, OP_STORE, 32'h8011_0023, 1'b0);
        @(negedge clk);
        check("release_word2", out_word, 32'hABCD_E137);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("release_word3", out_word, 32'h8011_0023);
        @(posedge clk);
        #1;
        drain();

        // Saturation
        for (int i = 0; i < 300; i++) begin
            send(3'b111, i, 5'd1, 5'd1, 5'd1, 3'd1, OP_IMM, NOP_WORD, 1'b1);
        end
        drain();
        check("err_count_sat", 32'(err_count), 32'd255);

        // Asynchronous reset with both stages full
        out_ready = 1'b0;
        send(3'b111, 32'd1, 5'd0, 5'd0, 5'd0, 3'd0, OP_IMM, NOP_WORD, 1'b1);
        send(3'b110, 32'd2, 5'd0, 5'd0, 5'd0, 3'd0, OP_IMM, NOP_WORD, 1'b1);
        check("full_in_ready", 32'(in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_word", out_word, 32'd0);
        check("arst_out_err", 32'(out_err), 32'd0);
        check("arst_err_count", 32'(err_count), 32'd0);
        @(negedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("no_stale_valid", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        send(IMM_U, 32'hFFFF_F000, 5'd31, 5'd0, 5'd0, 3'd0, OP_AUIPC, 32'hFFFF_FF97, 1'b0);
        drain();
        check("final_err_count", 32'(err_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
